// File: rtl/conv_layer_sequencer_if.sv
// Control/status bundle between the system controller, the conv stage
// wrappers and conv_layer_sequencer.
interface conv_layer_sequencer_if #(
    parameter int NUM_LAYERS = 4,
    parameter int CNT_W      = 32
);
    localparam int IDX_W = $clog2(NUM_LAYERS);

    logic                  start;
    logic                  abort;
    logic [NUM_LAYERS-1:0] layer_bypass;
    logic [NUM_LAYERS-1:0] layer_done;
    logic [NUM_LAYERS-1:0] layer_start;
    logic [NUM_LAYERS-1:0] layer_ena;
    logic [IDX_W-1:0]      cur_layer;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [CNT_W-1:0]      cycle_count;

    modport master (
        output start, abort, layer_bypass, layer_done,
        input  layer_start, layer_ena, cur_layer,
        input  busy, done, err, cycle_count
    );

    modport slave (
        input  start, abort, layer_bypass, layer_done,
        output layer_start, layer_ena, cur_layer,
        output busy, done, err, cycle_count
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Sequences the conv stage chain: start pulse, held enable, wait for done edge.
// Optional per-layer watchdog when LAYER_TIMEOUT_EN is defined.
module conv_layer_sequencer #(
    parameter int NUM_LAYERS     = 4,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic                   clk,
    input logic                   rst,
    conv_layer_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LAYERS);

    typedef enum logic [2:0] {
        IDLE, ISSUE, RUN, NEXT, FINISH, ERROR
    } state_t;

    state_t                state;
    logic [NUM_LAYERS-1:0] bypass_q;
    logic [NUM_LAYERS-1:0] done_q;
    logic [NUM_LAYERS-1:0] start_q;
    logic [NUM_LAYERS-1:0] ena_q;
    logic [IDX_W-1:0]      cur_q;
    logic                  busy_q;
    logic                  fin_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W:0]        first_pick;
    logic [IDX_W:0]        next_pick;
    logic                  run_edge;

    // MSB flags a hit; lowest non-bypassed index at or above 'from'
    function automatic logic [IDX_W:0] pick(
        input logic [NUM_LAYERS-1:0] byp,
        input int                    from
    );
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (i >= from && !byp[i]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    function automatic logic [NUM_LAYERS-1:0] oh(input logic [IDX_W-1:0] i);
        return NUM_LAYERS'(1) << i;
    endfunction

    always_comb begin
        first_pick = pick(bus.layer_bypass, 0);
        next_pick  = pick(bypass_q, int'(cur_q) + 1);
        run_edge   = bus.layer_done[cur_q] & ~done_q[cur_q];
    end

`ifdef LAYER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q;
    logic            wd_hit;

    assign wd_hit  = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign bus.err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else if (state != IDLE && bus.abort) begin
            wd_q <= wd_q;
        end else begin
            unique case (state)
                IDLE:  if (bus.start) err_q <= 1'b0;
                ISSUE: wd_q <= '0;
                RUN: begin
                    wd_q <= wd_q + 1'b1;
                    if (!run_edge && wd_hit) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
`else
    logic wd_hit;
    assign wd_hit  = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bypass_q <= '0;
            done_q   <= '0;
            start_q  <= '0;
            ena_q    <= '0;
            cur_q    <= '0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q  <= bus.layer_done;
            start_q <= '0;
            fin_q   <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state  <= IDLE;
                ena_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                if (state != IDLE && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                unique case (state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            bypass_q <= bus.layer_bypass;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            if (first_pick[IDX_W]) begin
                                cur_q   <= first_pick[IDX_W-1:0];
                                start_q <= oh(first_pick[IDX_W-1:0]);
                                ena_q   <= oh(first_pick[IDX_W-1:0]);
                                state   <= ISSUE;
                            end else begin
                                state <= FINISH;
                            end
                        end
                    end
                    ISSUE: state <= RUN;
                    RUN: begin
                        if (run_edge) begin
                            ena_q <= '0;
                            state <= NEXT;
                        end else if (wd_hit) begin
                            ena_q <= '0;
                            state <= ERROR;
                        end
                    end
                    NEXT: begin
                        if (next_pick[IDX_W]) begin
                            cur_q   <= next_pick[IDX_W-1:0];
                            start_q <= oh(next_pick[IDX_W-1:0]);
                            ena_q   <= oh(next_pick[IDX_W-1:0]);
                            state   <= ISSUE;
                        end else begin
                            state <= FINISH;
                        end
                    end
                    FINISH: begin
                        fin_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    ERROR: begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.layer_start = start_q;
    assign bus.layer_ena   = ena_q;
    assign bus.cur_layer   = cur_q;
    assign bus.busy        = busy_q;
    assign bus.done        = fin_q;
    assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer (4 layers); define LAYER_TIMEOUT_EN
// to also exercise the watchdog with an 8-cycle limit.
module tb_conv_layer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    conv_layer_sequencer_if #(.NUM_LAYERS(4), .CNT_W(32)) bus ();

    conv_layer_sequencer #(
        .NUM_LAYERS(4), .CNT_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".start"}, 64'(bus.layer_start), 64'h0);
        chk({tag, ".ena"},   64'(bus.layer_ena),   64'h0);
        chk({tag, ".cur"},   64'(bus.cur_layer),   64'h0);
        chk({tag, ".busy"},  64'(bus.busy),        64'h0);
        chk({tag, ".done"},  64'(bus.done),        64'h0);
        chk({tag, ".err"},   64'(bus.err),         64'h0);
        chk({tag, ".cnt"},   64'(bus.cycle_count), 64'h0);
    endtask

    // Entered right after the ISSUE edge; leaves right after the edge
    // that exits NEXT.
    task automatic run_layer(input int idx, input int run_cycles,
                             input string tag);
        logic [3:0] m;
        m = 4'b0001 << idx;
        chk({tag, ".issue_start"}, 64'(bus.layer_start), 64'(m));
        chk({tag, ".issue_ena"},   64'(bus.layer_ena),   64'(m));
        chk({tag, ".issue_cur"},   64'(bus.cur_layer),   64'(idx));
        step();
        chk({tag, ".run_start"}, 64'(bus.layer_start), 64'h0);
        chk({tag, ".run_ena"},   64'(bus.layer_ena),   64'(m));
        repeat (run_cycles - 1) step();
        chk({tag, ".run_busy"}, 64'(bus.busy), 64'h1);
        bus.layer_done = m;
        step();
        chk({tag, ".next_ena"}, 64'(bus.layer_ena), 64'h0);
        chk({tag, ".next_done"}, 64'(bus.done), 64'h0);
        bus.layer_done = 4'b0000;
        step();
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.layer_bypass = 4'b0000;
        bus.layer_done   = 4'b0000;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // full chain, no bypass, 5 RUN cycles each
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("full.busy", 64'(bus.busy), 64'h1);
        run_layer(0, 5, "full.l0");
        run_layer(1, 5, "full.l1");
        run_layer(2, 5, "full.l2");
        run_layer(3, 5, "full.l3");
        chk("full.fin_busy", 64'(bus.busy), 64'h1);
        chk("full.fin_done", 64'(bus.done), 64'h0);
        step();
        chk("full.done", 64'(bus.done), 64'h1);
        chk("full.busy_low", 64'(bus.busy), 64'h0);
        chk("full.cnt", 64'(bus.cycle_count), 64'd29);
        chk("full.err", 64'(bus.err), 64'h0);
        step();
        chk("full.done_pulse", 64'(bus.done), 64'h0);
        chk("full.cnt_hold", 64'(bus.cycle_count), 64'd29);

        // bypass 0101: layers 1 and 3, bypass change mid-run ignored
        bus.layer_bypass = 4'b0101;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.layer_bypass = 4'b0000;
        run_layer(1, 3, "byp.l1");
        run_layer(3, 3, "byp.l3");
        step();
        chk("byp.done", 64'(bus.done), 64'h1);
        chk("byp.cnt", 64'(bus.cycle_count), 64'd11);

        // all bypassed
        bus.layer_bypass = 4'b1111;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.layer_bypass = 4'b0000;
        chk("all.busy", 64'(bus.busy), 64'h1);
        chk("all.start", 64'(bus.layer_start), 64'h0);
        chk("all.no_done_yet", 64'(bus.done), 64'h0);
        step();
        chk("all.done", 64'(bus.done), 64'h1);
        chk("all.cnt", 64'(bus.cycle_count), 64'd1);

        // stale done level, foreign edge, then abort in layer 1
        bus.layer_done = 4'b0001;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("lvl.issue", 64'(bus.layer_start), 64'h1);
        step();
        step();
        bus.layer_done = 4'b0100;
        step();
        chk("lvl.held_ena", 64'(bus.layer_ena), 64'h1);
        step();
        step();
        chk("lvl.foreign_ena", 64'(bus.layer_ena), 64'h1);
        chk("lvl.foreign_cur", 64'(bus.cur_layer), 64'h0);
        bus.layer_done = 4'b0001;
        step();
        chk("lvl.next_ena", 64'(bus.layer_ena), 64'h0);
        bus.layer_done = 4'b0000;
        step();
        chk("lvl.l1_start", 64'(bus.layer_start), 64'h2);
        chk("lvl.l1_cur", 64'(bus.cur_layer), 64'h1);
        step();
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort.ena", 64'(bus.layer_ena), 64'h0);
        chk("abort.busy", 64'(bus.busy), 64'h0);
        chk("abort.cnt", 64'(bus.cycle_count), 64'd9);
        step();
        chk("abort.no_done", 64'(bus.done), 64'h0);

        // restart from layer 0, start while busy ignored
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("restart.start", 64'(bus.layer_start), 64'h1);
        chk("restart.cur", 64'(bus.cur_layer), 64'h0);
        chk("restart.cnt", 64'(bus.cycle_count), 64'd0);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("midstart.start", 64'(bus.layer_start), 64'h0);
        chk("midstart.ena", 64'(bus.layer_ena), 64'h1);
        chk("midstart.cnt", 64'(bus.cycle_count), 64'd2);

        // asynchronous reset mid-run
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        step();
        rst = 1'b0;
        step();

        // start with abort in IDLE stays idle
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa.busy", 64'(bus.busy), 64'h0);
        chk("sa.ena", 64'(bus.layer_ena), 64'h0);

`ifdef LAYER_TIMEOUT_EN
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (8) step();
        chk("wd.r8_ena", 64'(bus.layer_ena), 64'h1);
        chk("wd.r8_err", 64'(bus.err), 64'h0);
        step();
        chk("wd.err", 64'(bus.err), 64'h1);
        chk("wd.ena", 64'(bus.layer_ena), 64'h0);
        step();
        chk("wd.busy", 64'(bus.busy), 64'h0);
        chk("wd.no_done", 64'(bus.done), 64'h0);
        chk("wd.err_sticky", 64'(bus.err), 64'h1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("wd.err_clr", 64'(bus.err), 64'h0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
`else
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (12) step();
        chk("nowd.ena", 64'(bus.layer_ena), 64'h1);
        chk("nowd.err", 64'(bus.err), 64'h0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
`endif
        chk("end.busy", 64'(bus.busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
